// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the single register-file write port between the
// pipeline WB stage and a small FIFO of multi-cycle mult/div results.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_writeW,
    input  logic [4:0]  write_regW,
    input  logic [31:0] result_to_writeW,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_reqW,
    output logic [1:0]  buf_count
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_reg0, r_reg1;
    logic [31:0]   r_data0, r_data1;
    logic [1:0]    r_count;
    logic [CW-1:0] r_starve;

    logic          w_stall, w_busy, w_accept, w_pop, w_bypass, w_push;
    logic          w_keep0, w_keep1;
    logic [1:0]    w_left, w_ncount;
    logic [4:0]    w_nreg0, w_nreg1;
    logic [31:0]   w_ndata0, w_ndata1;

    // MDU handshake: a result transfers on a cycle where mdu_valid and mdu_ready are
    // both high; mdu_ready depends only on the registered count, never on this
    // cycle's drain, so the MDU must hold its offer until it sees ready.
    assign mdu_ready = (r_count < 2'(DEPTH));
    assign buf_count = r_count;

    // Everything is gated with rst_n so the port stays quiet while reset is held.
    assign w_stall  = rst_n && (r_count != 2'd0) && (r_starve == CW'(STARVE_LIMIT));
    assign w_busy   = rst_n && reg_writeW && (write_regW != 5'd0) && !w_stall;
    assign w_accept = rst_n && mdu_valid && mdu_ready;
    assign w_pop    = rst_n && !w_busy && (r_count != 2'd0);
    assign w_bypass = !w_busy && (r_count == 2'd0) && w_accept && (mdu_reg != 5'd0);
    assign w_push   = w_accept && (mdu_reg != 5'd0) && !w_bypass;
    assign stall_reqW = w_stall;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (w_busy) begin
            rf_we    = 1'b1;
            rf_waddr = write_regW;
            rf_wdata = result_to_writeW;
        end else if (w_pop) begin
            rf_we    = 1'b1;
            rf_waddr = r_reg0;
            rf_wdata = r_data0;
        end else if (w_bypass) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_reg;
            rf_wdata = mdu_data;
        end
    end

    // A busy write is younger than any buffered result, so matching entries are
    // dropped; survivors are compacted toward the head before the push lands.
    always_comb begin
        w_keep0  = (r_count != 2'd0) && !w_pop && !(w_busy && (r_reg0 == write_regW));
        w_keep1  = (r_count == 2'd2) && !(w_busy && (r_reg1 == write_regW));
        w_nreg0  = r_reg0;
        w_ndata0 = r_data0;
        w_nreg1  = r_reg1;
        w_ndata1 = r_data1;
        w_left   = 2'd0;
        if (w_keep0 && w_keep1) begin
            w_left = 2'd2;
        end else if (w_keep0) begin
            w_left = 2'd1;
        end else if (w_keep1) begin
            w_nreg0  = r_reg1;
            w_ndata0 = r_data1;
            w_left   = 2'd1;
        end
        if (w_push) begin
            if (w_left == 2'd0) begin
                w_nreg0  = mdu_reg;
                w_ndata0 = mdu_data;
            end else begin
                w_nreg1  = mdu_reg;
                w_ndata1 = mdu_data;
            end
        end
        w_ncount = w_left + {1'b0, w_push};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg0   <= 5'd0;
            r_reg1   <= 5'd0;
            r_data0  <= 32'd0;
            r_data1  <= 32'd0;
            r_count  <= 2'd0;
            r_starve <= '0;
        end else begin
            r_reg0  <= w_nreg0;
            r_reg1  <= w_nreg1;
            r_data0 <= w_ndata0;
            r_data1 <= w_ndata1;
            r_count <= w_ncount;
            if (w_pop || (w_ncount == 2'd0)) begin
                r_starve <= '0;
            end else if ((r_count != 2'd0) && (r_starve != CW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes go into a queue, a negedge
// monitor compares every register-file write against the queue head.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_writeW = 1'b0;
    logic [4:0]  write_regW = 5'd0;
    logic [31:0] result_to_writeW = 32'd0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_reg = 5'd0;
    logic [31:0] mdu_data = 32'd0;
    logic        mdu_ready, rf_we, stall_reqW;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  buf_count;

    logic [36:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_writeW(reg_writeW), .write_regW(write_regW), .result_to_writeW(result_to_writeW),
        .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_reqW(stall_reqW), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic pw, input logic [4:0] preg, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        reg_writeW = pw; write_regW = preg; result_to_writeW = pd;
        mdu_valid = mv; mdu_reg = mr; mdu_data = md;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write seen while out of reset must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected none", rf_waddr, rf_wdata);
            end else begin
                chk("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset with a busy pipeline and an MDU offer: the port must stay silent.
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd5, 32'h55);
        #12;
        chk("rst_rf_port", {rf_we, rf_waddr, rf_wdata}, 38'd0);
        chk("rst_count", buf_count, 0);
        chk("rst_ready", mdu_ready, 1);
        chk("rst_stall", stall_reqW, 0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Bypass: idle slot, empty buffer.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        expect_wr(5'd5, 32'h1234);
        @(negedge clk); chk("bypass_count", buf_count, 0);
        tick();
        chk("bypass_count_after", buf_count, 0);

        // Busy pipeline wins, MDU result buffered and drained next idle cycle.
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        expect_wr(5'd3, 32'hA);
        @(negedge clk); chk("b_count0", buf_count, 0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd7, 32'hB);
        @(negedge clk); chk("b_count1", buf_count, 1);
        tick();
        @(negedge clk); chk("b_count_drained", buf_count, 0);
        tick();

        // Fill the buffer under a busy pipeline; third offer waits until the forced drain.
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA0);
        expect_wr(5'd1, 32'h100);
        tick();
        drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'hB0);
        expect_wr(5'd2, 32'h200);
        @(negedge clk); chk("c_ready_one", mdu_ready, 1);
        tick();
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd3, 32'h300);
        @(negedge clk);
        chk("c_count_full", buf_count, 2);
        chk("c_ready_full", mdu_ready, 0);
        tick();
        drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd4, 32'h400);
        tick();
        drive(1'b1, 5'd5, 32'h500, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd5, 32'h500);
        @(negedge clk); chk("c_no_stall_yet", stall_reqW, 0);
        tick();
        drive(1'b1, 5'd6, 32'h600, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd10, 32'hA0);
        @(negedge clk);
        chk("c_stall", stall_reqW, 1);
        chk("c_ready_in_stall", mdu_ready, 0);
        tick();
        expect_wr(5'd6, 32'h600);
        @(negedge clk);
        chk("c_stall_once", stall_reqW, 0);
        chk("c_ready_after_pop", mdu_ready, 1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd11, 32'hB0);
        @(negedge clk); chk("c_count_refilled", buf_count, 2);
        tick();
        expect_wr(5'd12, 32'hC0);
        tick();
        @(negedge clk); chk("c_drained", buf_count, 0);
        tick();

        // One buffered entry starved by a busy pipeline: stall on the 5th cycle.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'hD0);
        expect_wr(5'd1, 32'h11);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i + 1), 32'(i), 1'b0, 5'd0, 32'd0);
            expect_wr(5'(i + 1), 32'(i));
            @(negedge clk); chk("d_no_stall", stall_reqW, 0);
            tick();
        end
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd20, 32'hD0);
        @(negedge clk); chk("d_stall", stall_reqW, 1);
        tick();
        expect_wr(5'd6, 32'h66);
        @(negedge clk);
        chk("d_stall_released", stall_reqW, 0);
        chk("d_count", buf_count, 0);
        tick();

        // Kill of a stale buffered entry, discard of register 0, same-cycle push survives.
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
        expect_wr(5'd1, 32'h1);
        tick();
        drive(1'b1, 5'd9, 32'h909, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'h909);
        @(negedge clk); chk("e_count_before_kill", buf_count, 1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("e_count_killed", buf_count, 0);
        chk("e_port_idle", {rf_we, rf_waddr, rf_wdata}, 38'd0);
        tick();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'hFF);
        expect_wr(5'd4, 32'h44);
        tick();
        drive(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'hEE);
        @(negedge clk);
        chk("e_reg0_count", buf_count, 0);
        chk("e_reg0_no_write", rf_we, 0);
        tick();
        drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd8, 32'h88);
        expect_wr(5'd8, 32'h8);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd8, 32'h88);
        @(negedge clk); chk("e_same_reg_pushed", buf_count, 1);
        tick();

        // Reset mid-operation with two buffered entries.
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD13);
        expect_wr(5'd1, 32'h1);
        tick();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'hD14);
        expect_wr(5'd2, 32'h2);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("f_count_full", buf_count, 2);
        rst_n = 1'b0;
        #2;
        chk("f_rst_count", buf_count, 0);
        chk("f_rst_we", rf_we, 0);
        chk("f_rst_ready", mdu_ready, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("f_post_rst_count", buf_count, 0);
        end
        tick();

        chk("exp_q_drained", 37'(exp_q.size()), 37'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
